// File: rtl/alu_divider_32_if.sv
// Request/result bundle for the 32-bit divider. A request is a one-cycle start
// pulse. It is taken only while busy=0, and its result is valid in the one cycle where done=1.
interface alu_divider_32_if;
  logic        start;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;
  logic [1:0]  state_dbg;

  modport master (output start, sign, a, b,
                  input  busy, done, quot, rem, div_zero, state_dbg);
  modport slave  (input  start, sign, a, b,
                  output busy, done, quot, rem, div_zero, state_dbg);
endinterface

// File: rtl/alu_divider_32.sv
// 32-bit signed/unsigned restoring divider. It runs one quotient bit per cycle, then a sign fix-up.
// Divide by zero returns quot=all ones, rem=dividend in a single cycle.
module alu_divider_32 (
  input  logic             clk,
  input  logic             reset,
  alu_divider_32_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        a_neg, b_neg;
  logic [31:0] bmag, dq, rp;
  logic [31:0] amag_in, bmag_in;
  logic [32:0] shifted, diff;
  logic [5:0]  cnt;
  logic [31:0] quot_r, rem_r;
  logic        dz_r;

  assign amag_in = (bus.sign && bus.a[31]) ? -bus.a : bus.a;
  assign bmag_in = (bus.sign && bus.b[31]) ? -bus.b : bus.b;

  // Shift the next dividend bit into the partial remainder, then trial-subtract the divisor.
  assign shifted = {rp, dq[31]};
  assign diff    = shifted - {1'b0, bmag};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.b == 32'd0) ? DONE : CALC;
      CALC: if (cnt == 6'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      bmag   <= 32'd0;
      dq     <= 32'd0;
      rp     <= 32'd0;
      cnt    <= 6'd0;
      quot_r <= 32'd0;
      rem_r  <= 32'd0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_neg <= bus.sign & bus.a[31];
          b_neg <= bus.sign & bus.b[31];
          bmag  <= bmag_in;
          dq    <= amag_in;
          rp    <= 32'd0;
          cnt   <= 6'd0;
          dz_r  <= 1'b0;
          if (bus.b == 32'd0) begin
            dz_r   <= 1'b1;
            quot_r <= 32'hFFFF_FFFF;
            rem_r  <= bus.a;
          end
        end
        CALC: begin
          // No borrow means the divisor fit and this quotient bit is 1.
          rp  <= diff[32] ? shifted[31:0] : diff[31:0];
          dq  <= {dq[30:0], ~diff[32]};
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          quot_r <= (a_neg ^ b_neg) ? -dq : dq;
          rem_r  <= a_neg ? -rp : rp;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.quot      = quot_r;
  assign bus.rem       = rem_r;
  assign bus.div_zero  = dz_r;
  assign bus.state_dbg = state;

endmodule
